// File: rtl/free_list_pkg.sv
// Shared defaults and the tag type for the multi-port free list.
package free_list_pkg;

  localparam int FL_DEPTH = 32;
  localparam int FL_TAG_W = 6;

  typedef logic [FL_TAG_W-1:0] tag_t;

endpackage

// File: rtl/prefix_count.sv
// Exclusive prefix popcount: for each bit i, how many set bits lie below i,
// plus the total number of set bits.
module prefix_count #(
  parameter int N  = 3,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]    i_vec,
  output logic [N*CW-1:0] o_prefix,
  output logic [CW-1:0]   o_total
);

  // Running sum across the vector, emitted before each bit is added.
  always_comb begin
    logic [CW-1:0] acc;
    acc      = '0;
    o_prefix = '0;
    for (int i = 0; i < N; i++) begin
      o_prefix[i*CW +: CW] = acc;
      acc = acc + CW'(i_vec[i]);
    end
    o_total = acc;
  end

endmodule

// File: rtl/free_list_nport.sv
// Circular free list of tags with several compacting allocate and free ports,
// a commit pointer for retirement and a flush that rewinds speculative grants.
module free_list_nport
  import free_list_pkg::*;
#(
  parameter int DEPTH     = FL_DEPTH,
  parameter int TAG_W     = FL_TAG_W,
  parameter int NUM_ALLOC = 3,
  parameter int NUM_FREE  = 3,
  parameter int TAG_BASE  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_ALLOC-1:0]           alloc_req,
  output logic [NUM_ALLOC-1:0]           alloc_gnt,
  output logic [NUM_ALLOC*TAG_W-1:0]     alloc_tag,
  input  logic [NUM_FREE-1:0]            free_en,
  input  logic [NUM_FREE*TAG_W-1:0]      free_tag,
  input  logic [$clog2(NUM_ALLOC+1)-1:0] commit_cnt,
  input  logic                           flush,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           empty,
  output logic                           full,
  output logic                           err_ovf,
  output logic                           err_unf
);

  localparam int IW  = $clog2(DEPTH);
  localparam int PW  = IW + 1;
  localparam int ACW = $clog2(NUM_ALLOC + 1);
  localparam int FCW = $clog2(NUM_FREE + 1);

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_cm;
  logic             r_ovf;
  logic             r_unf;

  logic [NUM_ALLOC*ACW-1:0] w_apre;
  logic [ACW-1:0]           w_atot;
  logic [NUM_FREE*FCW-1:0]  w_fpre;
  logic [FCW-1:0]           w_ftot;
  logic [NUM_ALLOC-1:0]     w_gnt;
  logic [NUM_FREE-1:0]      w_facc;
  logic [PW-1:0]            w_count;
  logic [PW-1:0]            w_space;
  logic [PW-1:0]            w_ngnt;
  logic [PW-1:0]            w_nfree;
  logic [PW-1:0]            w_outst;
  logic [PW-1:0]            w_cm_nxt;
  logic                     w_drop;
  logic                     w_unf;

  prefix_count #(.N(NUM_ALLOC), .CW(ACW)) u_alloc_pc (
    .i_vec    (alloc_req),
    .o_prefix (w_apre),
    .o_total  (w_atot)
  );

  prefix_count #(.N(NUM_FREE), .CW(FCW)) u_free_pc (
    .i_vec    (free_en),
    .o_prefix (w_fpre),
    .o_total  (w_ftot)
  );

  // Wrap bits make the modular difference distinguish full from empty.
  assign w_count = r_wr - r_rd;
  assign w_space = PW'(DEPTH) - w_count;
  assign count   = w_count;
  assign empty   = (w_count == '0);
  assign full    = (w_count == PW'(DEPTH));
  assign err_ovf = r_ovf;
  assign err_unf = r_unf;
  assign alloc_gnt = w_gnt;

  // Compacted grants: the k-th requester reads slot rd+k while k is in stock.
  always_comb begin
    w_gnt     = '0;
    alloc_tag = '0;
    for (int i = 0; i < NUM_ALLOC; i++) begin
      if (alloc_req[i] && !rst && !flush &&
          (PW'(w_apre[i*ACW +: ACW]) < w_count)) begin
        w_gnt[i] = 1'b1;
        alloc_tag[i*TAG_W +: TAG_W] =
          r_mem[r_rd[IW-1:0] + IW'(w_apre[i*ACW +: ACW])];
      end
    end
    if (rst || flush)
      w_ngnt = '0;
    else if (PW'(w_atot) < w_count)
      w_ngnt = PW'(w_atot);
    else
      w_ngnt = w_count;
  end

  // Compacted frees: the m-th returner lands at wr+m while space remains.
  always_comb begin
    w_facc = '0;
    for (int j = 0; j < NUM_FREE; j++)
      w_facc[j] = free_en[j] && (PW'(w_fpre[j*FCW +: FCW]) < w_space);
    w_drop  = |(free_en & ~w_facc);
    w_nfree = (PW'(w_ftot) < w_space) ? PW'(w_ftot) : w_space;
  end

  // Retirement cannot pass the allocation pointer; overshoot clamps and flags.
  always_comb begin
    w_outst = r_rd - r_cm;
    w_unf   = (PW'(commit_cnt) > w_outst);
    w_cm_nxt = w_unf ? r_rd : (r_cm + PW'(commit_cnt));
  end

  // Tag storage: identity-style preload on reset, accepted frees written after.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= TAG_W'(TAG_BASE + i);
    end else begin
      for (int j = 0; j < NUM_FREE; j++)
        if (w_facc[j])
          r_mem[r_wr[IW-1:0] + IW'(w_fpre[j*FCW +: FCW])] <= free_tag[j*TAG_W +: TAG_W];
    end
  end

  // Pointers: flush rewinds the read pointer onto the freshly updated commit point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0;
      r_cm <= '0;
      r_wr <= PW'(DEPTH);
    end else begin
      r_rd <= flush ? w_cm_nxt : (r_rd + w_ngnt);
      r_cm <= w_cm_nxt;
      r_wr <= r_wr + w_nfree;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_drop;
      r_unf <= r_unf | w_unf;
    end
  end

endmodule

// File: tb/tb_free_list_nport.sv
// Bench for free_list_nport: behavioural list model feeding an expected-grant queue.
module tb_free_list_nport;
  import free_list_pkg::*;

  localparam int DEPTH = 32;

  typedef struct {
    logic [2:0]  gnt;
    logic [17:0] tags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alloc_req;
  logic [2:0]  alloc_gnt;
  logic [17:0] alloc_tag;
  logic [2:0]  free_en;
  logic [17:0] free_tag;
  logic [1:0]  commit_cnt;
  logic        flush;
  logic [5:0]  count;
  logic        empty, full, err_ovf, err_unf;

  int n_vec = 0;
  int n_mis = 0;

  exp_t exp_q[$];
  tag_t m_mem [DEPTH];
  int   m_rd, m_wr, m_cm;
  logic m_ovf, m_unf;

  free_list_nport dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_tag(alloc_tag), .free_en(free_en), .free_tag(free_tag),
    .commit_cnt(commit_cnt), .flush(flush), .count(count), .empty(empty),
    .full(full), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1);
  end

  function automatic int mcnt();
    return m_wr - m_rd;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = tag_t'(32 + i);
    m_rd = 0; m_cm = 0; m_wr = DEPTH; m_ovf = 1'b0; m_unf = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    alloc_req = '0; free_en = '0; free_tag = '0; commit_cnt = '0; flush = 1'b0;
  endtask

  // Apply one cycle of stimulus and advance the model to its post-edge state.
  task automatic drive(input logic [2:0] req, input logic [2:0] fen,
                       input logic [17:0] ftag, input logic [1:0] cc, input logic fl);
    exp_t e;
    int k, m, ng, na, c, sp, outst;
    alloc_req = req; free_en = fen; free_tag = ftag; commit_cnt = cc; flush = fl;
    e.gnt = '0; e.tags = '0;
    k = 0; ng = 0; c = mcnt();
    for (int i = 0; i < 3; i++) if (req[i]) begin
      if (k < c && !fl) begin
        e.gnt[i] = 1'b1;
        e.tags[i*6 +: 6] = m_mem[(m_rd + k) % DEPTH];
        ng++;
      end
      k++;
    end
    m = 0; na = 0; sp = DEPTH - c;
    for (int j = 0; j < 3; j++) if (fen[j]) begin
      if (m < sp) begin
        m_mem[(m_wr + m) % DEPTH] = ftag[j*6 +: 6];
        na++;
      end else m_ovf = 1'b1;
      m++;
    end
    outst = m_rd - m_cm;
    if (int'(cc) > outst) begin m_cm = m_rd; m_unf = 1'b1; end
    else m_cm = m_cm + int'(cc);
    m_rd = fl ? m_cm : m_rd + ng;
    m_wr = m_wr + na;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    rst = 1'b1; idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0; model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; alloc_req = 3'b111; free_en = 3'b111; free_tag = 18'h0_1234;
    commit_cnt = 2'd3; flush = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if (alloc_gnt !== 3'b000 || alloc_tag !== 18'h0) begin
        n_mis++;
        $display("FAIL reset_outputs: gnt=%b tag=%h, want 000/0", alloc_gnt, alloc_tag);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; idle_inputs(); model_reset();
    n_vec++;
    if (count !== 6'd32 || full !== 1'b1 || empty !== 1'b0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_state: count=%0d full=%b empty=%b ovf=%b unf=%b, want 32/1/0/0/0",
               count, full, empty, err_ovf, err_unf);
    end
  endtask

  task automatic test_alloc3();
    exp_t e;
    apply_reset();
    drive(3'b111, 3'b000, 18'h0, 2'd0, 1'b0);
    @(negedge clk); e = exp_q.pop_front();
    n_vec++;
    if (alloc_gnt !== 3'b111 || alloc_tag !== {6'd34, 6'd33, 6'd32} || alloc_tag !== e.tags) begin
      n_mis++;
      $display("FAIL alloc3: gnt=%b tag=%h, want 111/%h", alloc_gnt, alloc_tag, {6'd34, 6'd33, 6'd32});
    end
    @(posedge clk); #1;
    n_vec++;
    if (count !== 6'd29) begin
      n_mis++; $display("FAIL alloc3_count: count=%0d, want 29", count);
    end
  endtask

  task automatic test_compact();
    exp_t e;
    apply_reset();
    drive(3'b101, 3'b000, 18'h0, 2'd0, 1'b0);
    @(negedge clk); e = exp_q.pop_front();
    n_vec++;
    if (alloc_gnt !== 3'b101 || alloc_tag !== {6'd33, 6'd0, 6'd32} || alloc_gnt !== e.gnt) begin
      n_mis++;
      $display("FAIL compact: gnt=%b tag=%h, want 101/%h", alloc_gnt, alloc_tag, {6'd33, 6'd0, 6'd32});
    end
    @(posedge clk); #1;
    drive(3'b010, 3'b000, 18'h0, 2'd0, 1'b0);
    @(negedge clk); e = exp_q.pop_front();
    n_vec++;
    if (alloc_gnt !== 3'b010 || alloc_tag !== {6'd0, 6'd34, 6'd0} || alloc_tag !== e.tags) begin
      n_mis++;
      $display("FAIL compact_next: gnt=%b tag=%h, want 010/%h", alloc_gnt, alloc_tag, {6'd0, 6'd34, 6'd0});
    end
    @(posedge clk); #1;
    n_vec++;
    if (count !== 6'd29) begin
      n_mis++; $display("FAIL compact_count: count=%0d, want 29", count);
    end
  endtask

  task automatic test_drain();
    exp_t e;
    logic [2:0] req;
    apply_reset();
    for (int c = 0; c < 13; c++) begin
      req = (c == 10) ? 3'b001 : 3'b111;
      drive(req, 3'b000, 18'h0, 2'd0, 1'b0);
      @(negedge clk); e = exp_q.pop_front();
      n_vec++;
      if (alloc_gnt !== e.gnt || alloc_tag !== e.tags) begin
        n_mis++;
        $display("FAIL drain_c%0d: gnt=%b tag=%h, want %b/%h", c, alloc_gnt, alloc_tag, e.gnt, e.tags);
      end
      if (c == 11) begin
        n_vec++;
        if (alloc_gnt !== 3'b001 || alloc_tag !== {12'h0, 6'd63}) begin
          n_mis++;
          $display("FAIL drain_last: gnt=%b tag=%h, want 001/%h", alloc_gnt, alloc_tag, {12'h0, 6'd63});
        end
      end
      @(posedge clk); #1;
      n_vec++;
      if (count !== 6'(mcnt()) || empty !== (mcnt() == 0)) begin
        n_mis++;
        $display("FAIL drain_count_c%0d: count=%0d empty=%b, want %0d", c, count, empty, mcnt());
      end
    end
    n_vec++;
    if (empty !== 1'b1 || count !== 6'd0) begin
      n_mis++; $display("FAIL drain_empty: empty=%b count=%0d, want 1/0", empty, count);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    apply_reset();
    repeat (2) begin
      drive(3'b111, 3'b000, 18'h0, 2'd0, 1'b0);
      @(negedge clk); void'(exp_q.pop_front());
      @(posedge clk); #1;
    end
    drive(3'b111, 3'b001, {12'h0, 6'd33}, 2'd2, 1'b1);
    @(negedge clk); e = exp_q.pop_front();
    n_vec++;
    if (alloc_gnt !== 3'b000 || alloc_gnt !== e.gnt) begin
      n_mis++; $display("FAIL flush_nogrant: gnt=%b, want 000", alloc_gnt);
    end
    @(posedge clk); #1;
    n_vec++;
    if (count !== 6'd31 || count !== 6'(mcnt())) begin
      n_mis++; $display("FAIL flush_count: count=%0d, want 31", count);
    end
    drive(3'b001, 3'b000, 18'h0, 2'd0, 1'b0);
    @(negedge clk); e = exp_q.pop_front();
    n_vec++;
    if (alloc_gnt !== 3'b001 || alloc_tag !== {12'h0, 6'd34} || alloc_tag !== e.tags) begin
      n_mis++; $display("FAIL flush_realloc: gnt=%b tag=%h, want 001/%h", alloc_gnt, alloc_tag, {12'h0, 6'd34});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ovf();
    apply_reset();
    drive(3'b000, 3'b001, {12'h0, 6'd7}, 2'd0, 1'b0);
    @(negedge clk); void'(exp_q.pop_front());
    @(posedge clk); #1;
    n_vec++;
    if (count !== 6'd32 || err_ovf !== 1'b1) begin
      n_mis++; $display("FAIL ovf_full: count=%0d ovf=%b, want 32/1", count, err_ovf);
    end
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (err_ovf !== 1'b1) begin
      n_mis++; $display("FAIL ovf_sticky: ovf=%b, want 1", err_ovf);
    end
    apply_reset();
    n_vec++;
    if (err_ovf !== 1'b0) begin
      n_mis++; $display("FAIL ovf_clear: ovf=%b, want 0", err_ovf);
    end
    drive(3'b001, 3'b000, 18'h0, 2'd0, 1'b0);
    @(negedge clk); void'(exp_q.pop_front());
    @(posedge clk); #1;
    drive(3'b000, 3'b111, {6'd11, 6'd10, 6'd32}, 2'd0, 1'b0);
    @(negedge clk); void'(exp_q.pop_front());
    @(posedge clk); #1;
    n_vec++;
    if (count !== 6'd32 || err_ovf !== 1'b1 || err_ovf !== m_ovf) begin
      n_mis++; $display("FAIL ovf_partial: count=%0d ovf=%b, want 32/1", count, err_ovf);
    end
  endtask

  task automatic test_unf();
    apply_reset();
    drive(3'b000, 3'b000, 18'h0, 2'd1, 1'b0);
    @(negedge clk); void'(exp_q.pop_front());
    @(posedge clk); #1;
    n_vec++;
    if (err_unf !== 1'b1 || err_unf !== m_unf || err_ovf !== 1'b0) begin
      n_mis++; $display("FAIL unf: unf=%b ovf=%b, want 1/0", err_unf, err_ovf);
    end
  endtask

  task automatic test_random();
    exp_t e;
    tag_t held[$];
    logic [2:0]  req, fen;
    logic [17:0] ft;
    int nf, left, idx, outst, cc, dup;
    tag_t t;
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      req = 3'($urandom_range(0, 7));
      nf = $urandom_range(0, (held.size() < 3) ? held.size() : 3);
      left = nf; fen = '0; ft = '0;
      for (int j = 0; j < 3; j++) begin
        if (left > 0 && ($urandom_range(0, 1) == 1 || (3 - j) == left)) begin
          idx = $urandom_range(0, held.size() - 1);
          fen[j] = 1'b1;
          ft[j*6 +: 6] = held[idx];
          held.delete(idx);
          left--;
        end
      end
      outst = m_rd - m_cm;
      cc = $urandom_range(0, (outst < 3) ? outst : 3);
      drive(req, fen, ft, 2'(cc), 1'b0);
      @(negedge clk); e = exp_q.pop_front();
      n_vec++;
      if (alloc_gnt !== e.gnt || alloc_tag !== e.tags) begin
        n_mis++;
        $display("FAIL rand_grant_c%0d: gnt=%b tag=%h, want %b/%h", c, alloc_gnt, alloc_tag, e.gnt, e.tags);
      end
      for (int i = 0; i < 3; i++) if (alloc_gnt[i]) begin
        t = alloc_tag[i*6 +: 6];
        dup = 0;
        foreach (held[h]) if (held[h] == t) dup = 1;
        n_vec++;
        if (dup != 0) begin
          n_mis++; $display("FAIL rand_unique_c%0d: tag %0d granted while live", c, t);
        end
        held.push_back(e.tags[i*6 +: 6]);
      end
      @(posedge clk); #1;
      n_vec++;
      if (count !== 6'(mcnt()) || full !== (mcnt() == DEPTH) || empty !== (mcnt() == 0)) begin
        n_mis++;
        $display("FAIL rand_count_c%0d: count=%0d full=%b empty=%b, want %0d", c, count, full, empty, mcnt());
      end
    end
    n_vec++;
    if (err_ovf !== m_ovf || err_unf !== m_unf) begin
      n_mis++; $display("FAIL rand_flags: ovf=%b unf=%b, want %b/%b", err_ovf, err_unf, m_ovf, m_unf);
    end
  endtask

  initial begin
    test_reset();
    test_alloc3();
    test_compact();
    test_drain();
    test_flush();
    test_ovf();
    test_unf();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
